timestamp_fifo: RTL and testbench

- Sits directly downstream of the 64-bit clock counter and consumes its free-running count.
- Up to NUM_SOURCES cores raise single-cycle event strobes. Each strobe captures the counter value in the cycle it arrives, tagged with source index and event code.
- Captured records are queued in a DEPTH-entry FIFO. Software drains the FIFO through an Avalon-MM slave using the same low-then-high snapshot read discipline as the counter, so multicore code can be profiled with one timebase.

---
 rtl/timestamp_fifo_pkg.sv | 25 ++
 rtl/timestamp_fifo_mem.sv | 58 +++++
 rtl/timestamp_fifo.sv | 229 ++++++++++++++++++++++
 tb/tb_timestamp_fifo.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timestamp_fifo_pkg.sv
// timestamp_fifo_pkg: shared constants and the FIFO record layout for the
// event timestamp FIFO (register addresses, status/tag bit positions, entry_t).
package timestamp_fifo_pkg;

   localparam logic [1:0] ADDR_TS_LO  = 2'd0;
   localparam logic [1:0] ADDR_TS_HI  = 2'd1;
   localparam logic [1:0] ADDR_TAG    = 2'd2;
   localparam logic [1:0] ADDR_STATUS = 2'd3;

   localparam int STATUS_LEVEL_LSB = 0;
   localparam int STATUS_EMPTY_BIT = 16;
   localparam int STATUS_FULL_BIT  = 17;
   localparam int STATUS_DROP_LSB  = 24;

   localparam int TAG_CODE_LSB  = 0;
   localparam int TAG_SRC_LSB   = 8;
   localparam int TAG_VALID_BIT = 31;

   typedef struct packed {
      logic [63:0] ts;
      logic [3:0]  src;
      logic [7:0]  code;
   } entry_t;

endpackage

// File: rtl/timestamp_fifo_mem.sv
// timestamp_fifo_mem: DEPTH-entry record store with show-ahead head read,
// level/full/empty tracking and a synchronous flush. A push into a full FIFO
// is accepted only when a pop frees the head slot in the same cycle.
module timestamp_fifo_mem
   import timestamp_fifo_pkg::*;
#(
   parameter int DEPTH = 16,
   localparam int AW = $clog2(DEPTH)
)
(
   input  logic          clock,
   input  logic          reset,
   input  logic          flush,
   input  logic          push,
   input  entry_t        wdata,
   input  logic          pop,
   output entry_t        rdata,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   level
);

   entry_t        store [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign empty   = (level == '0);
   assign full    = (level == (AW+1)'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rdata   = store[rd_ptr];

   // Pointer and level bookkeeping; flush empties the FIFO without touching storage
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)      level <= level + 1'b1;
         else if (!do_push && do_pop) level <= level - 1'b1;
      end
   end

   // Storage array has no reset so it can map onto RAM
   always_ff @(posedge clock) begin
      if (do_push && !flush) store[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/timestamp_fifo.sv
// timestamp_fifo: captures the free-running 64-bit counter on per-source event
// strobes, arbitrates pending captures round-robin into a record FIFO and
// exposes it through an Avalon-MM slave (low-then-high snapshot read).
// Optional feature macro: TIMESTAMP_FIFO_IRQ_EN adds the irq output and a
// level threshold register written at address 2.
module timestamp_fifo
   import timestamp_fifo_pkg::*;
#(
   parameter int NUM_SOURCES = 4,
   parameter int DEPTH       = 16,
   parameter int CODE_W      = 8
)
(
   input  logic                          clock,
   input  logic                          reset,
   input  logic [63:0]                   timestamp,
   input  logic [NUM_SOURCES-1:0]        event_valid,
   input  logic [NUM_SOURCES*CODE_W-1:0] event_code,
   input  logic                          csr_read,
   input  logic                          csr_write,
   input  logic [1:0]                    csr_address,
   input  logic [31:0]                   csr_writedata,
   output logic [31:0]                   csr_readdata
`ifdef TIMESTAMP_FIFO_IRQ_EN
   ,
   output logic                          irq
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int SW = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1;

   logic [NUM_SOURCES-1:0] pending;
   logic [63:0]            pending_ts   [NUM_SOURCES];
   logic [CODE_W-1:0]      pending_code [NUM_SOURCES];

   logic [SW-1:0]          rr_ptr;
   logic [SW:0]            cand;
   logic                   grant_valid;
   logic [SW-1:0]          grant_idx;
   logic [NUM_SOURCES-1:0] grant_vec;

   logic                   flush;
   logic                   pop_req;
   logic                   fifo_drop;
   logic [5:0]             drop_inc;
   logic [8:0]             drop_sum;
   logic [7:0]             drop_count;

   entry_t                 push_entry;
   entry_t                 head;
   logic                   full;
   logic                   empty;
   logic [AW:0]            level;

   logic [31:0]            snap_hi;
   logic [31:0]            snap_tag;
   logic [31:0]            status_word;
   logic [31:0]            head_tag;

   assign flush   = csr_write && (csr_address == ADDR_STATUS);
   assign pop_req = csr_read && (csr_address == ADDR_TS_LO) && !flush;

   // A grant into a full FIFO is lost unless a pop frees the head slot this cycle
   assign fifo_drop = grant_valid && full && !pop_req;

   // Round-robin arbiter: scan from rr_ptr upward, first pending source wins
   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = '0;
      cand        = '0;
      for (int k = NUM_SOURCES - 1; k >= 0; k--) begin
         cand = (SW+1)'(rr_ptr) + (SW+1)'(k);
         if (cand >= (SW+1)'(NUM_SOURCES)) cand = cand - (SW+1)'(NUM_SOURCES);
         if (pending[cand[SW-1:0]]) begin
            grant_valid = 1'b1;
            grant_idx   = cand[SW-1:0];
         end
      end
   end

   // One-hot view of the grant for the per-source pending update
   always_comb begin
      grant_vec = '0;
      if (grant_valid) grant_vec[grant_idx] = 1'b1;
   end

   // Record presented to the FIFO for the granted source
   always_comb begin
      push_entry.ts   = pending_ts[grant_idx];
      push_entry.src  = 4'(grant_idx);
      push_entry.code = 8'(pending_code[grant_idx]);
   end

   // Number of events lost this cycle: strobes into busy slots plus a full-FIFO discard
   always_comb begin
      drop_inc = 6'(fifo_drop);
      for (int i = 0; i < NUM_SOURCES; i++) begin
         if (event_valid[i] && pending[i] && !grant_vec[i]) drop_inc = drop_inc + 6'd1;
      end
      drop_sum = {1'b0, drop_count} + 9'(drop_inc);
   end

   // Capture strobes into per-source slots; a slot granted this cycle can take a new strobe
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pending <= '0;
         for (int i = 0; i < NUM_SOURCES; i++) begin
            pending_ts[i]   <= '0;
            pending_code[i] <= '0;
         end
      end else if (flush) begin
         pending <= '0;
      end else begin
         for (int i = 0; i < NUM_SOURCES; i++) begin
            if (event_valid[i] && (!pending[i] || grant_vec[i])) begin
               pending[i]      <= 1'b1;
               pending_ts[i]   <= timestamp;
               pending_code[i] <= event_code[i*CODE_W +: CODE_W];
            end else if (grant_vec[i]) begin
               pending[i] <= 1'b0;
            end
         end
      end
   end

   // Round-robin pointer moves to the source after the one just granted
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rr_ptr <= '0;
      end else if (grant_valid) begin
         if (grant_idx == SW'(NUM_SOURCES - 1)) rr_ptr <= '0;
         else                                   rr_ptr <= grant_idx + 1'b1;
      end
   end

   // Saturating drop counter, cleared by flush
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         drop_count <= '0;
      end else if (flush) begin
         drop_count <= '0;
      end else if (drop_sum > 9'd255) begin
         drop_count <= 8'hFF;
      end else begin
         drop_count <= drop_sum[7:0];
      end
   end

   timestamp_fifo_mem #(.DEPTH(DEPTH)) u_mem (
      .clock (clock),
      .reset (reset),
      .flush (flush),
      .push  (grant_valid && !flush),
      .wdata (push_entry),
      .pop   (pop_req),
      .rdata (head),
      .full  (full),
      .empty (empty),
      .level (level)
   );

   // Status and tag words assembled from live state and the FIFO head
   always_comb begin
      status_word = '0;
      status_word[STATUS_LEVEL_LSB +: 16] = 16'(level);
      status_word[STATUS_EMPTY_BIT]       = empty;
      status_word[STATUS_FULL_BIT]        = full;
      status_word[STATUS_DROP_LSB +: 8]   = drop_count;
      head_tag = '0;
      head_tag[TAG_VALID_BIT]      = 1'b1;
      head_tag[TAG_SRC_LSB +: 4]   = head.src;
      head_tag[TAG_CODE_LSB +: 8]  = head.code;
   end

   // Low-word read pops the head and snapshots its high word and tag
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         snap_hi  <= '0;
         snap_tag <= '0;
      end else if (flush) begin
         snap_hi  <= '0;
         snap_tag <= '0;
      end else if (pop_req) begin
         if (!empty) begin
            snap_hi  <= head.ts[63:32];
            snap_tag <= head_tag;
         end else begin
            snap_hi  <= '0;
            snap_tag <= '0;
         end
      end
   end

   // Registered read data with one cycle of latency
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         csr_readdata <= '0;
      end else if (csr_read) begin
         case (csr_address)
            ADDR_TS_LO:  csr_readdata <= (pop_req && !empty) ? head.ts[31:0] : 32'd0;
            ADDR_TS_HI:  csr_readdata <= snap_hi;
            ADDR_TAG:    csr_readdata <= snap_tag;
            default:     csr_readdata <= status_word;
         endcase
      end
   end

`ifdef TIMESTAMP_FIFO_IRQ_EN
   logic [7:0] threshold;
   logic       unused_bits;
   assign unused_bits = ^csr_writedata[31:8];

   // Threshold register and registered interrupt on level or any drop
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         threshold <= 8'd1;
         irq       <= 1'b0;
      end else begin
         if (csr_write && (csr_address == ADDR_TAG)) threshold <= csr_writedata[7:0];
         irq <= (16'(level) >= {8'h00, threshold}) || (drop_count != 8'd0);
      end
   end
`else
   logic unused_bits;
   assign unused_bits = ^csr_writedata;
`endif

endmodule

// File: tb/tb_timestamp_fifo.sv
// tb_timestamp_fifo: directed self-checking bench for timestamp_fifo covering
// reset, capture latency, round-robin order, drop rules, full FIFO, flush and
// (when TIMESTAMP_FIFO_IRQ_EN is defined) the interrupt threshold.
module tb_timestamp_fifo;

   logic        clock;
   logic        reset;
   logic [63:0] timestamp;
   logic [3:0]  event_valid;
   logic [31:0] event_code;
   logic        csr_read;
   logic        csr_write;
   logic [1:0]  csr_address;
   logic [31:0] csr_writedata;
   logic [31:0] csr_readdata;
`ifdef TIMESTAMP_FIFO_IRQ_EN
   logic        irq;
`endif

   int checks = 0;
   int fails  = 0;
   logic [31:0] rd;

   timestamp_fifo #(.NUM_SOURCES(4), .DEPTH(16), .CODE_W(8)) dut (
      .clock         (clock),
      .reset         (reset),
      .timestamp     (timestamp),
      .event_valid   (event_valid),
      .event_code    (event_code),
      .csr_read      (csr_read),
      .csr_write     (csr_write),
      .csr_address   (csr_address),
      .csr_writedata (csr_writedata),
      .csr_readdata  (csr_readdata)
`ifdef TIMESTAMP_FIFO_IRQ_EN
      ,
      .irq           (irq)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Advance one clock and settle just after the rising edge
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic csr_rd(input logic [1:0] addr, output logic [31:0] data);
      csr_read    = 1'b1;
      csr_address = addr;
      step();
      csr_read    = 1'b0;
      data        = csr_readdata;
   endtask

   task automatic csr_wr(input logic [1:0] addr, input logic [31:0] data);
      csr_write     = 1'b1;
      csr_address   = addr;
      csr_writedata = data;
      step();
      csr_write     = 1'b0;
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
      step();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) step();
      checks++;
      if (csr_readdata !== 32'h0) begin
         fails++;
         $display("[TB] FAIL reset_readdata: got %h expected %h", csr_readdata, 32'h0);
      end
`ifdef TIMESTAMP_FIFO_IRQ_EN
      checks++;
      if (irq !== 1'b0) begin
         fails++;
         $display("[TB] FAIL reset_irq: got %b expected 0", irq);
      end
`endif
      reset = 1'b0;
      step();
      csr_rd(2'd3, rd);
      checks++;
      if (rd !== 32'h00010000) begin
         fails++;
         $display("[TB] FAIL reset_status: got %h expected %h", rd, 32'h00010000);
      end
      csr_rd(2'd0, rd);
      checks++;
      if (rd !== 32'h0) begin
         fails++;
         $display("[TB] FAIL empty_pop: got %h expected %h", rd, 32'h0);
      end
      csr_rd(2'd2, rd);
      checks++;
      if (rd !== 32'h0) begin
         fails++;
         $display("[TB] FAIL empty_tag: got %h expected %h", rd, 32'h0);
      end
   endtask

   task automatic test_single_capture();
      timestamp   = 64'h0000_0001_0000_0010;
      event_valid = 4'b0100;
      event_code  = 32'h005A_0000;
      step();
      event_valid = 4'b0000;
      event_code  = 32'h0;
      timestamp   = 64'hDEAD_BEEF_CAFE_F00D;
      csr_rd(2'd3, rd);
      checks++;
      if (rd !== 32'h00010000) begin
         fails++;
         $display("[TB] FAIL latency_level_t1: got %h expected %h", rd, 32'h00010000);
      end
      csr_rd(2'd3, rd);
      checks++;
      if (rd !== 32'h00000001) begin
         fails++;
         $display("[TB] FAIL latency_level_t2: got %h expected %h", rd, 32'h00000001);
      end
      csr_rd(2'd0, rd);
      checks++;
      if (rd !== 32'h00000010) begin
         fails++;
         $display("[TB] FAIL single_ts_lo: got %h expected %h", rd, 32'h00000010);
      end
      csr_rd(2'd1, rd);
      checks++;
      if (rd !== 32'h00000001) begin
         fails++;
         $display("[TB] FAIL single_ts_hi: got %h expected %h", rd, 32'h00000001);
      end
      csr_rd(2'd2, rd);
      checks++;
      if (rd !== 32'h8000025A) begin
         fails++;
         $display("[TB] FAIL single_tag: got %h expected %h", rd, 32'h8000025A);
      end
   endtask

   task automatic test_rr_order();
      pulse_reset();
      timestamp   = 64'h1122_3344_5566_7788;
      event_valid = 4'hF;
      event_code  = 32'h1312_1110;
      step();
      event_valid = 4'h0;
      event_code  = 32'h0;
      repeat (4) step();
      csr_rd(2'd3, rd);
      checks++;
      if (rd !== 32'h00000004) begin
         fails++;
         $display("[TB] FAIL rr_level: got %h expected %h", rd, 32'h00000004);
      end
      for (int i = 0; i < 4; i++) begin
         csr_rd(2'd0, rd);
         checks++;
         if (rd !== 32'h55667788) begin
            fails++;
            $display("[TB] FAIL rr_ts_lo[%0d]: got %h expected %h", i, rd, 32'h55667788);
         end
         if (i == 0) begin
            csr_rd(2'd1, rd);
            checks++;
            if (rd !== 32'h11223344) begin
               fails++;
               $display("[TB] FAIL rr_ts_hi: got %h expected %h", rd, 32'h11223344);
            end
         end
         csr_rd(2'd2, rd);
         checks++;
         if (rd !== (32'h80000010 | (i << 8) | i)) begin
            fails++;
            $display("[TB] FAIL rr_tag[%0d]: got %h expected %h", i, rd, 32'h80000010 | (i << 8) | i);
         end
      end
   endtask

   task automatic test_drop_rules();
      logic [31:0] exp_lo  [4] = '{32'h100, 32'h100, 32'h200, 32'h201};
      logic [31:0] exp_tag [4] = '{32'h800000A0, 32'h800001A1, 32'h800001C1, 32'h800001D1};
      // source 0 and 1 pending, source 0 wins, source 1 strobes again -> dropped
      timestamp   = 64'h100;
      event_valid = 4'b0011;
      event_code  = 32'h0000_A1A0;
      step();
      timestamp   = 64'h101;
      event_valid = 4'b0010;
      event_code  = 32'h0000_B100;
      step();
      event_valid = 4'b0000;
      step();
      // source 1 alone: granted in the cycle of its second strobe -> latched
      timestamp   = 64'h200;
      event_valid = 4'b0010;
      event_code  = 32'h0000_C100;
      step();
      timestamp   = 64'h201;
      event_code  = 32'h0000_D100;
      step();
      event_valid = 4'b0000;
      event_code  = 32'h0;
      repeat (3) step();
      csr_rd(2'd3, rd);
      checks++;
      if (rd !== 32'h01000004) begin
         fails++;
         $display("[TB] FAIL drop_status: got %h expected %h", rd, 32'h01000004);
      end
      for (int i = 0; i < 4; i++) begin
         csr_rd(2'd0, rd);
         checks++;
         if (rd !== exp_lo[i]) begin
            fails++;
            $display("[TB] FAIL drop_ts_lo[%0d]: got %h expected %h", i, rd, exp_lo[i]);
         end
         csr_rd(2'd2, rd);
         checks++;
         if (rd !== exp_tag[i]) begin
            fails++;
            $display("[TB] FAIL drop_tag[%0d]: got %h expected %h", i, rd, exp_tag[i]);
         end
      end
   endtask

   task automatic test_full();
      csr_wr(2'd3, 32'h0);
      csr_rd(2'd3, rd);
      checks++;
      if (rd !== 32'h00010000) begin
         fails++;
         $display("[TB] FAIL flush_clears_drop: got %h expected %h", rd, 32'h00010000);
      end
      for (int i = 0; i < 20; i++) begin
         timestamp   = 64'h1000 + 64'(i);
         event_valid = 4'b0001;
         event_code  = 32'(i);
         step();
      end
      event_valid = 4'b0000;
      step();
      step();
      csr_rd(2'd3, rd);
      checks++;
      if (rd !== 32'h04020010) begin
         fails++;
         $display("[TB] FAIL full_status: got %h expected %h", rd, 32'h04020010);
      end
      // push lands in the same cycle as a pop of the oldest entry
      timestamp   = 64'h77;
      event_valid = 4'b0001;
      step();
      event_valid = 4'b0000;
      csr_rd(2'd0, rd);
      checks++;
      if (rd !== 32'h00001000) begin
         fails++;
         $display("[TB] FAIL full_pop_head: got %h expected %h", rd, 32'h00001000);
      end
      csr_rd(2'd3, rd);
      checks++;
      if (rd !== 32'h04020010) begin
         fails++;
         $display("[TB] FAIL push_pop_level: got %h expected %h", rd, 32'h04020010);
      end
   endtask

   task automatic test_flush();
      csr_wr(2'd3, 32'hFFFF_FFFF);
      csr_rd(2'd3, rd);
      checks++;
      if (rd !== 32'h00010000) begin
         fails++;
         $display("[TB] FAIL flush_status: got %h expected %h", rd, 32'h00010000);
      end
      csr_rd(2'd1, rd);
      checks++;
      if (rd !== 32'h0) begin
         fails++;
         $display("[TB] FAIL flush_snap_hi: got %h expected %h", rd, 32'h0);
      end
      // strobes coinciding with flush are discarded and not counted
      csr_write     = 1'b1;
      csr_address   = 2'd3;
      timestamp     = 64'h999;
      event_valid   = 4'hF;
      event_code    = 32'h4444_4444;
      step();
      csr_write     = 1'b0;
      event_valid   = 4'h0;
      repeat (4) step();
      csr_rd(2'd3, rd);
      checks++;
      if (rd !== 32'h00010000) begin
         fails++;
         $display("[TB] FAIL flush_vs_strobe: got %h expected %h", rd, 32'h00010000);
      end
   endtask

`ifdef TIMESTAMP_FIFO_IRQ_EN
   task automatic test_irq();
      csr_wr(2'd2, 32'h2);
      timestamp   = 64'h5555;
      event_valid = 4'b0011;
      event_code  = 32'h0000_0201;
      step();
      event_valid = 4'b0000;
      step();
      step();
      checks++;
      if (irq !== 1'b0) begin
         fails++;
         $display("[TB] FAIL irq_before: got %b expected 0", irq);
      end
      step();
      checks++;
      if (irq !== 1'b1) begin
         fails++;
         $display("[TB] FAIL irq_rise: got %b expected 1", irq);
      end
      csr_rd(2'd0, rd);
      checks++;
      if (irq !== 1'b1) begin
         fails++;
         $display("[TB] FAIL irq_hold: got %b expected 1", irq);
      end
      step();
      checks++;
      if (irq !== 1'b0) begin
         fails++;
         $display("[TB] FAIL irq_fall: got %b expected 0", irq);
      end
   endtask
`endif

   initial begin
      reset         = 1'b1;
      timestamp     = 64'h0;
      event_valid   = 4'h0;
      event_code    = 32'h0;
      csr_read      = 1'b0;
      csr_write     = 1'b0;
      csr_address   = 2'd0;
      csr_writedata = 32'h0;
      $display("[TB] starting timestamp_fifo bench");
      test_reset();
      test_single_capture();
      test_rr_order();
      test_drop_rules();
      test_full();
      test_flush();
`ifdef TIMESTAMP_FIFO_IRQ_EN
      test_irq();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
